bcd_disp_ctrl: RTL and testbench

Multi-digit BCD count-and-display controller. It holds DIGITS cascaded decimal digits that advance on a prescaled tick, accepts parallel loads, and time-multiplexes the digits onto one active-low common-anode 7-segment bus. It sits between the board clock/buttons and the physical display, replacing per-digit counter-plus-decoder instances.

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_seg_dec.sv | 27 ++
 rtl/bcd_disp_ctrl.sv | 143 ++++++++++++++
 tb/tb_bcd_disp_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants for the BCD count-and-display controller: blank pattern,
// active-low 7-segment codes for 0..9 and the largest legal BCD digit.
package bcd_pkg;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [3:0] BCD_MAX   = 4'd9;

   // Entry n is the active-low {dp,g..a} pattern for digit n; dp stays off.
   localparam logic [9:0][7:0] SEG_CODES = {
      8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
      8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };

   function automatic logic [3:0] bcdSanitize(input logic [3:0] nib);
      return (nib > BCD_MAX) ? 4'd0 : nib;
   endfunction

endpackage

// File: rtl/bcd_seg_dec.sv
// Combinational BCD to active-low common-anode segment decoder; codes above 9
// produce a dark digit.
module bcd_seg_dec
   import bcd_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [7:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      case (bcd_i)
         4'd0:    seg_o = SEG_CODES[0];
         4'd1:    seg_o = SEG_CODES[1];
         4'd2:    seg_o = SEG_CODES[2];
         4'd3:    seg_o = SEG_CODES[3];
         4'd4:    seg_o = SEG_CODES[4];
         4'd5:    seg_o = SEG_CODES[5];
         4'd6:    seg_o = SEG_CODES[6];
         4'd7:    seg_o = SEG_CODES[7];
         4'd8:    seg_o = SEG_CODES[8];
         4'd9:    seg_o = SEG_CODES[9];
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/bcd_disp_ctrl.sv
// Cascaded BCD counter with prescaled tick and parallel load, time-multiplexed
// onto one active-low 7-segment bus with optional leading-zero blanking.
module bcd_disp_ctrl
   import bcd_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int TICK_DIV = 50000,
   parameter int SCAN_DIV = 1000
)(
   input  logic                clk,
   input  logic                rst_syn,
   input  logic                en,
   input  logic                load,
   input  logic [4*DIGITS-1:0] load_val,
   input  logic                lzb,
   output logic [4*DIGITS-1:0] count_bcd,
   output logic                carry_out,
   output logic [7:0]          seg_out,
   output logic [DIGITS-1:0]   dig_sel
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int SW = $clog2(SCAN_DIV);
   localparam int IW = $clog2(DIGITS);

   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

   logic [PW-1:0]         presc_q, presc_d;
   logic [4*DIGITS-1:0]   count_q, count_d;
   logic                  carry_q, carry_d;
   logic [SW-1:0]         scan_q, scan_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [7:0]            seg_q, seg_d;
   logic [DIGITS-1:0]     dig_q, dig_d;

   logic                  tick;
   logic [DIGITS:0]       lowAllNine;
   logic [DIGITS:0]       upperZero;
   logic [3:0]            curNib;
   logic [7:0]            decSeg;
   logic                  blankDigit;

   assign tick = en && (presc_q == PRESC_LAST);

   always_comb begin
      presc_d = presc_q;
      if (load) begin
         presc_d = '0;
      end else if (en) begin
         presc_d = tick ? '0 : presc_q + PW'(1);
      end
   end

   // lowAllNine[i]: every digit below i is 9; upperZero[i]: digit i and above are 0.
   always_comb begin
      logic nineAcc;
      logic zeroAcc;
      nineAcc = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         lowAllNine[i] = nineAcc;
         nineAcc = nineAcc && (count_q[4*i +: 4] == BCD_MAX);
      end
      lowAllNine[DIGITS] = nineAcc;
      zeroAcc = 1'b1;
      upperZero[DIGITS] = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zeroAcc = zeroAcc && (count_q[4*i +: 4] == 4'd0);
         upperZero[i] = zeroAcc;
      end
   end

   for (genvar i = 0; i < DIGITS; i++) begin : gDigit
      logic [3:0] cur;
      logic [3:0] nibD;
      assign cur = count_q[4*i +: 4];
      always_comb begin
         nibD = cur;
         if (load) begin
            nibD = bcdSanitize(load_val[4*i +: 4]);
         end else if (tick && lowAllNine[i]) begin
            nibD = (cur == BCD_MAX) ? 4'd0 : cur + 4'd1;
         end
      end
      assign count_d[4*i +: 4] = nibD;
   end

   assign carry_d = tick && !load && lowAllNine[DIGITS];

   always_comb begin
      scan_d = scan_q + SW'(1);
      idx_d  = idx_q;
      if (scan_q == SCAN_LAST) begin
         scan_d = '0;
         idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      end
   end

   assign curNib     = count_q[{idx_q, 2'b00} +: 4];
   assign blankDigit = lzb && (idx_q != '0) && upperZero[idx_q];

   bcd_seg_dec uSegDec (
      .bcd_i (curNib),
      .seg_o (decSeg)
   );

   // Slot start is dead time so the previous digit's segments never ghost.
   always_comb begin
      seg_d = SEG_BLANK;
      dig_d = '1;
      if (scan_q != '0) begin
         dig_d = ~(DIGITS'(1) << idx_q);
         seg_d = blankDigit ? SEG_BLANK : decSeg;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_syn) begin
         presc_q <= '0;
         count_q <= '0;
         carry_q <= 1'b0;
         scan_q  <= '0;
         idx_q   <= '0;
         seg_q   <= SEG_BLANK;
         dig_q   <= '1;
      end else begin
         presc_q <= presc_d;
         count_q <= count_d;
         carry_q <= carry_d;
         scan_q  <= scan_d;
         idx_q   <= idx_d;
         seg_q   <= seg_d;
         dig_q   <= dig_d;
      end
   end

   assign count_bcd = count_q;
   assign carry_out = carry_q;
   assign seg_out   = seg_q;
   assign dig_sel   = dig_q;

endmodule

// File: tb/tb_bcd_disp_ctrl.sv
// Scoreboard bench for bcd_disp_ctrl: stimulus pushes cycle-stamped expected
// values, a negedge monitor pops and compares them against the outputs.
module tb_bcd_disp_ctrl;

   localparam int DIGITS   = 4;
   localparam int TICK_DIV = 4;
   localparam int SCAN_DIV = 3;

   localparam int K_COUNT = 0;
   localparam int K_CARRY = 1;
   localparam int K_SEG   = 2;
   localparam int K_DIG   = 3;

   logic                clk = 1'b0;
   logic                rst_syn;
   logic                en;
   logic                load;
   logic [4*DIGITS-1:0] load_val;
   logic                lzb;
   logic [4*DIGITS-1:0] count_bcd;
   logic                carry_out;
   logic [7:0]          seg_out;
   logic [DIGITS-1:0]   dig_sel;

   int testsRun    = 0;
   int testsFailed = 0;
   int cycleCnt    = 0;

   int          cycQ[$];
   int          kindQ[$];
   logic [31:0] expQ[$];
   string       nameQ[$];

   bcd_disp_ctrl #(
      .DIGITS   (DIGITS),
      .TICK_DIV (TICK_DIV),
      .SCAN_DIV (SCAN_DIV)
   ) dut (
      .clk       (clk),
      .rst_syn   (rst_syn),
      .en        (en),
      .load      (load),
      .load_val  (load_val),
      .lzb       (lzb),
      .count_bcd (count_bcd),
      .carry_out (carry_out),
      .seg_out   (seg_out),
      .dig_sel   (dig_sel)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   task automatic expectVal(input int kind, input logic [31:0] val, input string name);
      cycQ.push_back(cycleCnt);
      kindQ.push_back(kind);
      expQ.push_back(val);
      nameQ.push_back(name);
   endtask

   task automatic expectReset(input string name);
      expectVal(K_COUNT, 32'h0, {name, "_count"});
      expectVal(K_CARRY, 32'h0, {name, "_carry"});
      expectVal(K_SEG, 32'hFF, {name, "_seg"});
      expectVal(K_DIG, 32'hF, {name, "_dig"});
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Edge k after reset release: slot (k-1)/3 mod 4, first cycle of each slot dark.
   task automatic scanRun(input int kFirst, input int kLast, input logic [3:0][7:0] tab,
                          input string name);
      int s;
      for (int k = kFirst; k <= kLast; k++) begin
         step(1);
         if ((k - 1) % SCAN_DIV == 0) begin
            expectVal(K_SEG, 32'hFF, $sformatf("%s_dead_seg_k%0d", name, k));
            expectVal(K_DIG, 32'hF, $sformatf("%s_dead_dig_k%0d", name, k));
         end else begin
            s = ((k - 1) / SCAN_DIV) % DIGITS;
            expectVal(K_SEG, {24'h0, tab[s]}, $sformatf("%s_seg_k%0d", name, k));
            expectVal(K_DIG, {28'h0, ~(4'b0001 << s)}, $sformatf("%s_dig_k%0d", name, k));
         end
      end
   endtask

   task automatic checkOutput();
      int          kind;
      logic [31:0] expv;
      logic [31:0] act;
      string       name;
      void'(cycQ.pop_front());
      kind = kindQ.pop_front();
      expv = expQ.pop_front();
      name = nameQ.pop_front();
      case (kind)
         K_COUNT: act = {16'h0, count_bcd};
         K_CARRY: act = {31'h0, carry_out};
         K_SEG:   act = {24'h0, seg_out};
         default: act = {28'h0, dig_sel};
      endcase
      testsRun++;
      if (act !== expv) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cycleCnt);
      end
   endtask

   always @(negedge clk) begin
      while (cycQ.size() > 0 && cycQ[0] <= cycleCnt) checkOutput();
   end

   task automatic applyStimulus();
      rst_syn  = 1'b0;
      en       = 1'b0;
      load     = 1'b0;
      load_val = '0;
      lzb      = 1'b0;

      step(1);
      expectReset("rst1");
      step(1);
      expectReset("rst2");

      rst_syn = 1'b1;
      en      = 1'b1;
      step(3);
      expectVal(K_COUNT, 32'h0000, "cnt_before_first_tick");
      step(1);
      expectVal(K_COUNT, 32'h0001, "cnt_first_tick");
      step(36);
      expectVal(K_COUNT, 32'h0010, "cnt_40_cycles");
      expectVal(K_CARRY, 32'h0, "no_carry_40");

      en       = 1'b0;
      load     = 1'b1;
      load_val = 16'h9998;
      step(1);
      expectVal(K_COUNT, 32'h9998, "load_9998");
      load = 1'b0;
      en   = 1'b1;
      step(3);
      expectVal(K_COUNT, 32'h9998, "hold_9998");
      step(1);
      expectVal(K_COUNT, 32'h9999, "tick_9999");
      expectVal(K_CARRY, 32'h0, "no_carry_9999");
      step(3);
      expectVal(K_COUNT, 32'h9999, "hold_9999");
      step(1);
      expectVal(K_COUNT, 32'h0000, "rollover");
      expectVal(K_CARRY, 32'h1, "carry_pulse");
      step(1);
      expectVal(K_CARRY, 32'h0, "carry_one_cycle");
      expectVal(K_COUNT, 32'h0000, "after_rollover");

      step(2);
      load     = 1'b1;
      load_val = 16'h1234;
      step(1);
      expectVal(K_COUNT, 32'h1234, "load_beats_tick");
      expectVal(K_CARRY, 32'h0, "load_no_carry");
      load = 1'b0;
      step(3);
      expectVal(K_COUNT, 32'h1234, "presc_cleared_hold");
      step(1);
      expectVal(K_COUNT, 32'h1235, "presc_cleared_tick");
      en       = 1'b0;
      load     = 1'b1;
      load_val = 16'h12AF;
      step(1);
      expectVal(K_COUNT, 32'h1200, "load_sanitize");
      load = 1'b0;

      rst_syn = 1'b0;
      step(1);
      expectReset("rst_scan");
      rst_syn  = 1'b1;
      load     = 1'b1;
      load_val = 16'h1234;
      step(1);
      expectVal(K_SEG, 32'hFF, "scan_first_dead_seg");
      expectVal(K_DIG, 32'hF, "scan_first_dead_dig");
      load = 1'b0;
      scanRun(2, 15, {8'hF9, 8'hA4, 8'hB0, 8'h99}, "scan1234");

      rst_syn = 1'b0;
      step(1);
      expectReset("rst_lzb");
      rst_syn  = 1'b1;
      load     = 1'b1;
      load_val = 16'h0050;
      lzb      = 1'b1;
      step(1);
      expectVal(K_SEG, 32'hFF, "lzb_first_dead_seg");
      load = 1'b0;
      scanRun(2, 12, {8'hFF, 8'hFF, 8'h92, 8'hC0}, "lzb0050");
      load     = 1'b1;
      load_val = 16'h0000;
      step(1);
      expectVal(K_COUNT, 32'h0000, "load_zero");
      load = 1'b0;
      scanRun(14, 24, {8'hFF, 8'hFF, 8'hFF, 8'hC0}, "lzb0000");

      load     = 1'b1;
      load_val = 16'h0042;
      step(1);
      expectVal(K_COUNT, 32'h0042, "load_0042");
      load = 1'b0;
      scanRun(26, 46, {8'hFF, 8'hFF, 8'h99, 8'hA4}, "en0_scan");
      expectVal(K_COUNT, 32'h0042, "en0_hold");
      expectVal(K_CARRY, 32'h0, "en0_no_carry");

      rst_syn = 1'b0;
      step(1);
      expectReset("rst_midslot");
      rst_syn = 1'b1;
      step(1);
      expectVal(K_SEG, 32'hFF, "post_rst_dead_seg");
      expectVal(K_DIG, 32'hF, "post_rst_dead_dig");
      step(1);
      expectVal(K_SEG, 32'hC0, "post_rst_slot0_seg");
      expectVal(K_DIG, 32'hE, "post_rst_slot0_dig");
   endtask

   initial begin
      applyStimulus();
      for (int i = 0; i < 10 && cycQ.size() > 0; i++) @(negedge clk);
      #1;
      if (cycQ.size() > 0) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL drain: got %0d unchecked entries, expected 0", cycQ.size());
      end
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
